button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Input-side counterpart to the LED/state output path: turns raw, bouncing, asynchronous
//  board buttons into clean levels and single-cycle press/release/long-press events.
//  Sits between the top-level btn pins and the light-mode FSM.
//  The FSM consumes press_pulse[0] as its mode-toggle event instead of the raw btn[0].
// PARAMETERS
//  N_BTN            4        number of independent button channels
//  DEBOUNCE_CYCLES  1250000  cycles the synced input must differ from stable to be accepted (10 ms @125 MHz); >=2
//  LONG_CYCLES      125000000  cycles of stable-high hold before long_pulse (1 s @125 MHz); >=1
//  CNT_W            $clog2(max(DEBOUNCE_CYCLES,LONG_CYCLES)+1)  counter width, derived, not overridden
// PORTS
//  clk            in   1      system clock, all state on rising edge
//  rst_n          in   1      asynchronous, active-low reset
//  btn_raw        in   N_BTN  raw button pins, asynchronous to clk, active-high
//  btn_level      out  N_BTN  debounced button level
//  press_pulse    out  N_BTN  1-cycle strobe on debounced 0->1
//  release_pulse  out  N_BTN  1-cycle strobe on debounced 1->0
//  long_pulse     out  N_BTN  1-cycle strobe after LONG_CYCLES of continuous hold (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all sync flops, counters, btn_level, press/release/long_pulse = 0. Deassertion needs no sequencing.
//  - Per channel, fully independent; no cross-channel interaction.
//  - Sync: 2-flop synchroniser, sync = second flop; no logic between the flops.
//  - Debounce: db_cnt clears whenever sync == btn_level. While sync != btn_level, db_cnt increments.
//    When db_cnt == DEBOUNCE_CYCLES-1 and sync != btn_level, btn_level <= sync and db_cnt <= 0.
//  - Latency: if btn_raw holds a new value sampled at edge k, btn_level changes at edge k+DEBOUNCE_CYCLES+1.
//    Any reversion before then restarts the count, so glitches shorter than DEBOUNCE_CYCLES never propagate.
//  - press_pulse/release_pulse: registered, high exactly the first cycle btn_level shows the new value.
//    Never both high. Never high in consecutive cycles on one channel.
//  - Long press: hold_cnt clears while btn_level==0. It increments while btn_level==1 and saturates at LONG_CYCLES.
//    long_pulse is high for the single cycle hold_cnt transitions to LONG_CYCLES, i.e. LONG_CYCLES cycles after press_pulse.
//    Fires at most once per press. A release before that point produces no long_pulse.
//  - press_pulse is still issued at the start of a long press; consumers that need exclusivity act on release_pulse.
//  - Async reset mid-count: outputs and counters clear immediately. A button still held after reset
//    re-qualifies from zero and yields a fresh press_pulse.
//  - Counters never wrap: db_cnt bounded by DEBOUNCE_CYCLES-1, hold_cnt saturates.
// CONFIGURATION
//  `BTN_LONG_PRESS_EN defined: hold_cnt logic present, long_pulse as above.
//  Not defined: no hold_cnt flops; long_pulse tied to 0; port list unchanged.
// STRUCTURE
//  Shared package/header btn_pkg: CNT_W function, DEBOUNCE_CYCLES/LONG_CYCLES defaults per board clock.
//  Sub-module button_channel: sync, debounce, pulses and hold logic for one bit.
//  button_conditioner instantiates N_BTN channels via generate.
// TESTING (bench params: N_BTN=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=10)
//  1 rst_n=0 with btn_raw=4'hF -> all outputs 0. Release rst_n at edge 0 -> btn_level=4'hF and press_pulse=4'hF
//    at edge 5 for one cycle. Relative to the first sampling edge k=0 this is k+DEBOUNCE_CYCLES+1=5.
//  2 btn_raw[0] high for 3 cycles then low -> btn_level[0], press_pulse[0], release_pulse[0] stay 0.
//  3 btn_raw[1] toggles every cycle for 12 cycles, then steady 1 -> exactly one press_pulse[1],
//    5 cycles after the final edge; btn_level[1]=1.
//  4 btn_raw[2] held 25 cycles then low -> press_pulse[2] once; long_pulse[2] once, 10 cycles later (macro on)
//    or never (macro off); release_pulse[2] once, 5 cycles after the drop.
//  5 btn_raw[3] rises; rst_n pulsed low when db_cnt=2 -> outputs 0 immediately;
//    press_pulse[3] 5 cycles after rst_n rises.
//  6 btn_raw[0] and btn_raw[2] rise on the same edge -> press_pulse = 4'b0101 in the same cycle.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared constants for the button conditioner: board-clock defaults and the
// counter-width helper. Long-press logic is enabled with `BTN_LONG_PRESS_EN.
package btn_pkg;

  // Defaults for a 125 MHz board clock: 10 ms debounce, 1 s long press.
  localparam int DEBOUNCE_CYCLES_125M = 1250000;
  localparam int LONG_CYCLES_125M     = 125000000;

  // One counter width wide enough for both the debounce and hold counts.
  function automatic int cnt_w(input int deb, input int lng);
    int m;
    m = (deb > lng) ? deb : lng;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, debounce counter, press/release
// strobes and, with `BTN_LONG_PRESS_EN defined, a saturating hold counter
// driving the long-press strobe. Without the macro long_o is tied low.
module button_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_125M,
  parameter int LONG_CYCLES     = LONG_CYCLES_125M,
  parameter int CNT_W           = cnt_w(DEBOUNCE_CYCLES_125M, LONG_CYCLES_125M)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  logic             meta_q, sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             press_q, press_d, rel_q, rel_d;

  // Synchroniser: nothing between the two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= btn_raw_i;
      sync_q <= meta_q;
    end
  end

  // Debounce: count while sync disagrees with the level; accept on the last count.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    if (sync_q != level_q) begin
      if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync_q;
        press_d = sync_q;
        rel_d   = ~sync_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Debounce state and strobes; strobes coincide with the first new-level cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q  <= 1'b0;
      db_cnt_q <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

`ifdef BTN_LONG_PRESS_EN
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             long_q, long_d;

  // Hold counter: clears while released, saturates at LONG_CYCLES; strobe on arrival.
  always_comb begin
    hold_d = '0;
    long_d = 1'b0;
    if (level_q) begin
      if (hold_q != CNT_W'(LONG_CYCLES)) begin
        hold_d = hold_q + 1'b1;
        long_d = (hold_q == CNT_W'(LONG_CYCLES - 1));
      end else begin
        hold_d = hold_q;
      end
    end
  end

  // Hold counter and long-press strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw asynchronous buttons into debounced levels and
// single-cycle press/release/long-press strobes, one independent channel per
// button. Long press is present only with `BTN_LONG_PRESS_EN defined.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_125M,
  parameter int LONG_CYCLES     = LONG_CYCLES_125M
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse
);

  localparam int CNT_W = cnt_w(DEBOUNCE_CYCLES, LONG_CYCLES);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw_i (btn_raw[g]),
      .level_o   (btn_level[g]),
      .press_o   (press_pulse[g]),
      .release_o (release_pulse[g]),
      .long_o    (long_pulse[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (N_BTN=4, DEBOUNCE=4, LONG=10).
// Expected strobe events are queued with their cycle when stimulus is driven
// and compared in order as the DUT raises any strobe.
module tb_button_conditioner;

  localparam int N = 4;
  localparam int DB = 4;
  localparam int LG = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_raw, btn_level, press_pulse, release_pulse, long_pulse;

  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    int unsigned cyc;
    logic [N-1:0] p, r, l;
  } ev_t;
  ev_t q[$];

  button_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int unsigned at, input logic [N-1:0] p, input logic [N-1:0] r,
                      input logic [N-1:0] l);
    ev_t e;
    e.cyc = at; e.p = p; e.r = r; e.l = l;
    q.push_back(e);
  endtask

  // Push the long-press strobe only in builds where it exists.
  task automatic push_long(input int unsigned at, input logic [N-1:0] l);
`ifdef BTN_LONG_PRESS_EN
    push(at, '0, '0, l);
`else
    if (l == '1 && at == 0) push(at, '0, '0, l);  // never true: no long strobes expected
`endif
  endtask

  // Monitor: any strobe must match the next queued event, cycle included.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (press_pulse | release_pulse | long_pulse) != '0) begin
      if (q.size() == 0) begin
        chk("unexpected_evt", {20'h0, press_pulse, release_pulse, long_pulse}, 32'h0);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("evt_cycle", cyc, e.cyc);
        chk("evt_press", {28'h0, press_pulse}, {28'h0, e.p});
        chk("evt_release", {28'h0, release_pulse}, {28'h0, e.r});
        chk("evt_long", {28'h0, long_pulse}, {28'h0, e.l});
      end
    end
  end

  initial begin
    int unsigned k;
    rst_n   = 1'b0;
    btn_raw = 4'hF;

    // 1: reset with all buttons held, then release and qualify together
    tick(3);
    chk("rst_level", {28'h0, btn_level}, 32'h0);
    chk("rst_press", {28'h0, press_pulse}, 32'h0);
    chk("rst_release", {28'h0, release_pulse}, 32'h0);
    chk("rst_long", {28'h0, long_pulse}, 32'h0);
    rst_n = 1'b1;
    k = cyc + 1;
    push(k + DB + 1, 4'hF, 4'h0, 4'h0);
    push_long(k + DB + 1 + LG, 4'hF);
    tick(DB + 1);
    chk("s1_level_early", {28'h0, btn_level}, 32'h0);
    tick(13);
    chk("s1_level", {28'h0, btn_level}, 32'hF);
    btn_raw = 4'h0;
    k = cyc + 1;
    push(k + DB + 1, 4'h0, 4'hF, 4'h0);
    tick(10);
    chk("s1_level_off", {28'h0, btn_level}, 32'h0);

    // 2: 3-cycle glitch on btn 0 never propagates
    btn_raw[0] = 1'b1;
    tick(3);
    btn_raw[0] = 1'b0;
    tick(10);
    chk("s2_level", {28'h0, btn_level}, 32'h0);

    // 3: btn 1 chatters for 12 cycles, then settles high
    for (int i = 0; i < 12; i++) begin
      btn_raw[1] = (i % 2 == 0);
      tick(1);
    end
    btn_raw[1] = 1'b1;
    k = cyc + 1;
    push(k + DB + 1, 4'b0010, 4'h0, 4'h0);
    push_long(k + DB + 1 + LG, 4'b0010);
    tick(18);
    chk("s3_level", {28'h0, btn_level}, 32'h2);
    btn_raw[1] = 1'b0;
    k = cyc + 1;
    push(k + DB + 1, 4'h0, 4'b0010, 4'h0);
    tick(10);

    // 4: btn 2 held 25 cycles: press, long press, release
    btn_raw[2] = 1'b1;
    k = cyc + 1;
    push(k + DB + 1, 4'b0100, 4'h0, 4'h0);
    push_long(k + DB + 1 + LG, 4'b0100);
    tick(25);
    btn_raw[2] = 1'b0;
    k = cyc + 1;
    push(k + DB + 1, 4'h0, 4'b0100, 4'h0);
    tick(10);
    chk("s4_level", {28'h0, btn_level}, 32'h0);

    // 5: reset while btn 3 is mid-debounce; it re-qualifies from zero
    btn_raw[3] = 1'b1;
    k = cyc + 1;
    tick(4);                      // db_cnt = 2 now
    rst_n = 1'b0;
    #1;
    chk("s5_rst_level", {28'h0, btn_level}, 32'h0);
    chk("s5_rst_press", {28'h0, press_pulse}, 32'h0);
    #1;
    rst_n = 1'b1;
    k = cyc + 1;
    push(k + DB + 1, 4'b1000, 4'h0, 4'h0);
    tick(7);
    chk("s5_level", {28'h0, btn_level}, 32'h8);
    btn_raw[3] = 1'b0;            // release before long press: no long strobe
    k = cyc + 1;
    push(k + DB + 1, 4'h0, 4'b1000, 4'h0);
    tick(20);

    // 6: btn 0 and btn 2 rise together
    btn_raw = 4'b0101;
    k = cyc + 1;
    push(k + DB + 1, 4'b0101, 4'h0, 4'h0);
    push_long(k + DB + 1 + LG, 4'b0101);
    tick(18);
    chk("s6_level", {28'h0, btn_level}, 32'h5);
    btn_raw = 4'h0;
    k = cyc + 1;
    push(k + DB + 1, 4'h0, 4'b0101, 4'h0);
    tick(12);

    chk("queue_empty", q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
